cmos_pixel_capture: RTL

Capture front end for the CMOS camera port. Samples the camera's VSYNC, HREF, PCLK and 8-bit data in the system clock domain and assembles byte pairs into RGB565 pixels tagged with x/y coordinates. Pixels are buffered in a small FIFO and presented on a valid/ready stream. Downstream, the LCD SPI writer consumes this stream to paint the panel.

---
 rtl/cmos_pixel_capture_if.sv | 12 +
 rtl/cmos_pixel_capture.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cmos_pixel_capture_if.sv
// Pixel stream bundle between the camera capture front end and its consumer.
// Carries an RGB565 pixel tagged with its x/y position on a valid/ready handshake.
interface cmos_pixel_capture_if;
   logic        valid;
   logic        ready;
   logic [15:0] data;
   logic [8:0]  x;
   logic [7:0]  y;

   modport master (output valid, data, x, y, input ready);
   modport slave  (input valid, data, x, y, output ready);
endinterface

// File: rtl/cmos_pixel_capture.sv
// CMOS camera capture: synchronises VSYNC/HREF/PCLK/data, pairs bytes into
// RGB565 pixels with x/y tags, and buffers them in a small FWFT FIFO.
module cmos_pixel_capture #(
   parameter int FRAME_WIDTH  = 320,
   parameter int FRAME_HEIGHT = 240,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_cmosCam_verticalSync,
   input  logic                 io_cmosCam_horizontalRef,
   input  logic                 io_cmosCam_pixelclock,
   input  logic [7:0]           io_cmosCam_pixcelData,
   cmos_pixel_capture_if.master io_pixel,
   output logic                 io_frameStart,
   output logic                 io_frameDone,
   output logic                 io_overflow
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} state_t;

   typedef struct packed {
      logic [15:0] data;
      logic [8:0]  x;
      logic [7:0]  y;
   } pixel_t;

   // [0],[1] form the synchroniser, [2] is the edge-detect delay
   logic [2:0] vsSync, hrefSync, pclkSync;
   logic [7:0] dataS1, dataS2;

   logic vsRise, vsFall, hrefRise, hrefFall, byteEvt;
   logic [7:0] byteQ;

   state_t state, stateNext;
   logic   startD, doneD;
   logic   phase;
   logic [7:0] hiByte;
   logic [8:0] x;
   logic [7:0] y;
   logic   pixStrobe;
   pixel_t pixReg;

   pixel_t          mem [FIFO_DEPTH];
   logic [AW-1:0]   wrPtr, rdPtr;
   logic [AW:0]     count;
   logic            inRange, push, pop, full, wrEn;
   pixel_t          head;

   always_ff @(posedge clock) begin
      if (reset) begin
         vsSync   <= '0;
         hrefSync <= '0;
         pclkSync <= '0;
         dataS1   <= '0;
         dataS2   <= '0;
         vsRise   <= 1'b0;
         vsFall   <= 1'b0;
         hrefRise <= 1'b0;
         hrefFall <= 1'b0;
         byteEvt  <= 1'b0;
         byteQ    <= '0;
      end else begin
         vsSync   <= {vsSync[1:0], io_cmosCam_verticalSync};
         hrefSync <= {hrefSync[1:0], io_cmosCam_horizontalRef};
         pclkSync <= {pclkSync[1:0], io_cmosCam_pixelclock};
         dataS1   <= io_cmosCam_pixcelData;
         dataS2   <= dataS1;
         vsRise   <= vsSync[1] & ~vsSync[2];
         vsFall   <= ~vsSync[1] & vsSync[2];
         hrefRise <= hrefSync[1] & ~hrefSync[2];
         hrefFall <= ~hrefSync[1] & hrefSync[2];
         byteEvt  <= pclkSync[1] & ~pclkSync[2] & hrefSync[1];
         byteQ    <= dataS2;
      end
   end

   always_comb begin
      stateNext = state;
      startD    = 1'b0;
      doneD     = 1'b0;
      unique case (state)
         IDLE: stateNext = WAIT_FRAME;
         WAIT_FRAME: begin
            if (vsFall) begin
               startD    = 1'b1;
               stateNext = ACTIVE;
            end
         end
         ACTIVE: begin
            // a fall here means the rise was missed: restart the frame
            if (vsFall) begin
               startD = 1'b1;
            end else if (vsRise) begin
               doneD     = 1'b1;
               stateNext = WAIT_FRAME;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         io_frameStart <= 1'b0;
         io_frameDone  <= 1'b0;
         phase         <= 1'b0;
         hiByte        <= '0;
         x             <= '0;
         y             <= '0;
         pixStrobe     <= 1'b0;
         pixReg        <= '0;
      end else begin
         state         <= stateNext;
         io_frameStart <= startD;
         io_frameDone  <= doneD;
         pixStrobe     <= 1'b0;
         if (hrefRise) begin
            x     <= '0;
            phase <= 1'b0;
         end else if (state == ACTIVE && byteEvt) begin
            if (!phase) begin
               hiByte <= byteQ;
               phase  <= 1'b1;
            end else begin
               pixReg    <= '{data: {hiByte, byteQ}, x: x, y: y};
               pixStrobe <= 1'b1;
               phase     <= 1'b0;
               if (x != 9'd511) x <= x + 9'd1;
            end
         end
         if (state == ACTIVE && hrefFall && y != 8'd255) y <= y + 8'd1;
         if (startD) y <= '0;
      end
   end

   assign inRange = (int'(pixReg.x) < FRAME_WIDTH) &&
                    (int'(pixReg.y) < FRAME_HEIGHT);
   assign push = pixStrobe && inRange;
   assign pop  = io_pixel.valid && io_pixel.ready;
   assign full = (count == DEPTH);
   // a pop in the same cycle frees the slot for a push into a full FIFO
   assign wrEn = push && (!full || pop);

   always_ff @(posedge clock) begin
      if (wrEn) mem[wrPtr] <= pixReg;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr       <= '0;
         rdPtr       <= '0;
         count       <= '0;
         io_overflow <= 1'b0;
      end else begin
         if (wrEn) wrPtr <= wrPtr + AW'(1);
         if (pop) rdPtr <= rdPtr + AW'(1);
         unique case ({wrEn, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
         if (startD) io_overflow <= 1'b0;
         if (push && !wrEn) io_overflow <= 1'b1;
      end
   end

   assign head           = mem[rdPtr];
   assign io_pixel.valid = (count != '0);
   assign io_pixel.data  = io_pixel.valid ? head.data : '0;
   assign io_pixel.x     = io_pixel.valid ? head.x : '0;
   assign io_pixel.y     = io_pixel.valid ? head.y : '0;
endmodule
